// File: rtl/score_bcd_keeper.sv
// score_bcd_keeper
//   Tracks the session high score across game-over events and keeps converting either the
//   live score or the high score to packed BCD by sequential double-dabble.
//   The conversion runs continuously: 1 capture cycle, WIDTH shift cycles, 1 update cycle.
//
// Ports
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   count       live score, unsigned binary
//   game_over   game-over level; its rising edge commits the high score
//   show_high   conversion source select (0 = count, 1 = high_score)
//   bcd         packed BCD digits, [3:0] = ones
//   bcd_valid   set once the first conversion has completed
//   high_score  best committed score, unsigned binary
//   new_record  one-cycle pulse when high_score is replaced
module score_bcd_keeper #(
   parameter int unsigned WIDTH   = 24,
   parameter int unsigned DIGITS  = 6,
   parameter int unsigned BCD_MAX = 999999
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [WIDTH-1:0]      count,
   input  logic                  game_over,
   input  logic                  show_high,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  bcd_valid,
   output logic [WIDTH-1:0]      high_score,
   output logic                  new_record
);

   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] SatVal    = WIDTH'(BCD_MAX);
   localparam logic [CntW-1:0]  LastShift = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StCapture, StShift, StUpdate} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   bin_q, bin_d;
   logic [BcdW-1:0]    acc_q, acc_d;
   logic [BcdW-1:0]    acc_adj;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [BcdW-1:0]    bcd_q, bcd_d;
   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   src;

   logic               go_q;
   logic [WIDTH-1:0]   high_q;
   logic               rec_q;
   logic               go_rise;

   // ------------------------------------------------------------------
   // Double-dabble conversion
   // ------------------------------------------------------------------
   assign src = show_high ? high_q : count;

   // Digits >= 5 get +3 so the following left shift carries into the next digit.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      valid_d = valid_q;
      unique case (state_q)
         StCapture: begin
            bin_d   = (src > SatVal) ? SatVal : src;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StShift;
         end
         StShift: begin
            {acc_d, bin_d} = {acc_adj, bin_q} << 1;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == LastShift) begin
               state_d = StUpdate;
            end
         end
         StUpdate: begin
            bcd_d   = acc_q;
            valid_d = 1'b1;
            state_d = StCapture;
         end
         default: state_d = StCapture;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StCapture;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
      end
   end

   // ------------------------------------------------------------------
   // High-score tracking, independent of the conversion FSM
   // ------------------------------------------------------------------
   assign go_rise = game_over & ~go_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         go_q   <= 1'b0;
         high_q <= '0;
         rec_q  <= 1'b0;
      end else begin
         go_q <= game_over;
         // Strictly greater: tying the record is not a new record.
         if (go_rise && (count > high_q)) begin
            high_q <= count;
            rec_q  <= 1'b1;
         end else begin
            rec_q  <= 1'b0;
         end
      end
   end

   assign bcd        = bcd_q;
   assign bcd_valid  = valid_q;
   assign high_score = high_q;
   assign new_record = rec_q;

endmodule

// File: tb/tb_score_bcd_keeper.sv
module tb_score_bcd_keeper;

   logic        clk;
   logic        resetn;
   logic [23:0] count;
   logic        game_over;
   logic        show_high;
   logic [23:0] bcd;
   logic        bcd_valid;
   logic [23:0] high_score;
   logic        new_record;

   int vectors;
   int miscompares;

   // Behavioural model: conversion phase within the 26-cycle period plus decimal arithmetic.
   int          m_phase;
   logic [23:0] m_cap;
   logic [23:0] m_bcd;
   logic [23:0] m_high;
   logic        m_valid;
   logic        m_rec;
   logic        m_go;

   score_bcd_keeper dut (
      .clk        (clk),
      .resetn     (resetn),
      .count      (count),
      .game_over  (game_over),
      .show_high  (show_high),
      .bcd        (bcd),
      .bcd_valid  (bcd_valid),
      .high_score (high_score),
      .new_record (new_record)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] to_bcd(input int unsigned v);
      logic [23:0] r;
      int unsigned x;
      x = v;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_cap   = '0;
      m_bcd   = '0;
      m_high  = '0;
      m_valid = 1'b0;
      m_rec   = 1'b0;
      m_go    = 1'b0;
   endtask

   // Advance model and DUT by one clock; returns #1 after the edge.
   task automatic step();
      logic [23:0] src;
      logic [23:0] nh;
      logic        nr;
      if (m_phase == 0) begin
         src   = show_high ? m_high : count;
         m_cap = (src > 24'd999999) ? 24'd999999 : src;
      end
      if (game_over && !m_go && (count > m_high)) begin
         nh = count;
         nr = 1'b1;
      end else begin
         nh = m_high;
         nr = 1'b0;
      end
      if (m_phase == 25) begin
         m_bcd   = to_bcd(int'(m_cap));
         m_valid = 1'b1;
      end
      m_phase = (m_phase == 25) ? 0 : m_phase + 1;
      m_go    = game_over;
      m_high  = nh;
      m_rec   = nr;
      @(posedge clk);
      #1;
   endtask

   task automatic align();
      while (m_phase != 0) step();
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      count     = '0;
      game_over = 1'b0;
      show_high = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (bcd !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_bcd: got %h expected 000000", bcd);
      end
      vectors++;
      if (bcd_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: got %b expected 0", bcd_valid);
      end
      vectors++;
      if (high_score !== 24'h0 || new_record !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_high: got %h/%b expected 000000/0", high_score, new_record);
      end
      model_reset();
      resetn = 1'b1;
   endtask

   task automatic test_latency();
      count = 24'd123456;
      for (int i = 1; i <= 26; i++) begin
         step();
         vectors++;
         if (bcd_valid !== (i == 26)) begin
            miscompares++;
            $display("FAIL latency_valid edge %0d: got %b expected %b", i, bcd_valid, (i == 26));
         end
      end
      vectors++;
      if (bcd !== 24'h123456) begin
         miscompares++;
         $display("FAIL latency_bcd: got %h expected 123456", bcd);
      end
      for (int i = 1; i <= 26; i++) begin
         step();
         vectors++;
         if (bcd !== 24'h123456) begin
            miscompares++;
            $display("FAIL rewrite_bcd cycle %0d: got %h expected 123456", i, bcd);
         end
      end
   endtask

   task automatic test_saturate();
      align();
      count = 24'd2000000;
      repeat (26) step();
      vectors++;
      if (bcd !== 24'h999999) begin
         miscompares++;
         $display("FAIL saturate: got %h expected 999999", bcd);
      end
      count = 24'd0;
      repeat (13) step();
      vectors++;
      if (bcd !== 24'h999999) begin
         miscompares++;
         $display("FAIL hold_during_shift: got %h expected 999999", bcd);
      end
      repeat (13) step();
      vectors++;
      if (bcd !== 24'h000000) begin
         miscompares++;
         $display("FAIL zero: got %h expected 000000", bcd);
      end
   endtask

   task automatic test_game_over();
      logic [23:0] scores [3];
      logic        exp_rec [3];
      scores  = '{24'd500, 24'd300, 24'd500};
      exp_rec = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         count     = scores[i];
         game_over = 1'b1;
         step();
         vectors++;
         if (new_record !== exp_rec[i] || high_score !== 24'd500) begin
            miscompares++;
            $display("FAIL game_over %0d: got rec=%b high=%0d expected rec=%b high=500",
                     i, new_record, high_score, exp_rec[i]);
         end
         game_over = 1'b0;
         step();
         vectors++;
         if (new_record !== 1'b0) begin
            miscompares++;
            $display("FAIL record_width %0d: got %b expected 0", i, new_record);
         end
      end
   endtask

   task automatic test_hold();
      int pulses;
      pulses    = 0;
      count     = 24'd600;
      game_over = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (new_record === 1'b1) pulses++;
         count = count + 24'd1;
      end
      game_over = 1'b0;
      step();
      if (new_record === 1'b1) pulses++;
      vectors++;
      if (pulses != 1 || high_score !== 24'd600) begin
         miscompares++;
         $display("FAIL hold_game_over: got pulses=%0d high=%0d expected pulses=1 high=600",
                  pulses, high_score);
      end
   endtask

   task automatic test_show_high_mid();
      align();
      count     = 24'd777;
      show_high = 1'b0;
      repeat (13) step();
      show_high = 1'b1;
      count     = 24'd4321;
      repeat (13) step();
      vectors++;
      if (bcd !== 24'h000777) begin
         miscompares++;
         $display("FAIL show_high_current: got %h expected 000777", bcd);
      end
      repeat (26) step();
      vectors++;
      if (bcd !== 24'h000600) begin
         miscompares++;
         $display("FAIL show_high_next: got %h expected 000600", bcd);
      end
      show_high = 1'b0;
   endtask

   task automatic test_reset_mid();
      align();
      count = 24'd31337;
      repeat (13) step();
      #2;
      resetn = 1'b0;
      #1;
      vectors++;
      if (bcd !== 24'h0 || bcd_valid !== 1'b0 || high_score !== 24'h0 || new_record !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: got bcd=%h valid=%b high=%h rec=%b expected all zero",
                  bcd, bcd_valid, high_score, new_record);
      end
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      count  = 24'd42;
      repeat (25) step();
      vectors++;
      if (bcd_valid !== 1'b0 || bcd !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_mid_early: got valid=%b bcd=%h expected 0/000000", bcd_valid, bcd);
      end
      step();
      vectors++;
      if (bcd_valid !== 1'b1 || bcd !== 24'h000042) begin
         miscompares++;
         $display("FAIL reset_mid_conv: got valid=%b bcd=%h expected 1/000042", bcd_valid, bcd);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) count = 24'($urandom());
         else                           count = 24'($urandom_range(0, 1100000));
         game_over = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0) show_high = ~show_high;
         step();
         vectors++;
         if (bcd !== m_bcd || bcd_valid !== m_valid || high_score !== m_high ||
             new_record !== m_rec) begin
            miscompares++;
            $display("FAIL random cycle %0d: got bcd=%h v=%b hi=%h rec=%b expected %h %b %h %b",
                     i, bcd, bcd_valid, high_score, new_record, m_bcd, m_valid, m_high, m_rec);
         end
      end
      game_over = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_reset();
      test_reset();
      test_latency();
      test_saturate();
      test_game_over();
      test_hold();
      test_show_high_mid();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
